// File: rtl/sta_arrival_engine.sv
// Max-plus arrival propagator: per-net arrival file, worst-arrival tracker, query port.
// Latency: arc write lands 1 cycle after acceptance; qry_at is registered (1 cycle).
// Backpressure: arc_ready is low only during the NODES-cycle clear sweep.
module sta_arrival_engine #(
    parameter int NODES  = 64,
    parameter int NODE_W = 6,
    parameter int DLY_W  = 16,
    parameter int AT_W   = 24
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              arc_valid,
    output logic              arc_ready,
    input  logic [1:0]        arc_op,
    input  logic [NODE_W-1:0] arc_src,
    input  logic [NODE_W-1:0] arc_dst,
    input  logic [DLY_W-1:0]  arc_delay,
    input  logic [NODE_W-1:0] qry_node,
    output logic [AT_W-1:0]   qry_at,
    output logic [AT_W-1:0]   worst_at,
    output logic [NODE_W-1:0] worst_node,
    output logic              sat,
    output logic              busy
);
    localparam logic [1:0] OP_ARC   = 2'd0;
    localparam logic [1:0] OP_SEED  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic {S_CLR, S_RUN} state_t;

    state_t            state;
    logic [NODE_W-1:0] clr_cnt;
    logic [AT_W-1:0]   at_mem [NODES];

    logic              a_vld;
    logic [1:0]        a_op;
    logic [NODE_W-1:0] a_dst;
    logic [DLY_W-1:0]  a_dly;
    logic [AT_W-1:0]   a_src_at;

    logic              accept;
    logic              clear_acc;
    logic [AT_W:0]     b_sum;
    logic              b_ovf;
    logic [AT_W-1:0]   b_arc_at;
    logic [AT_W-1:0]   b_dst_at;
    logic [AT_W-1:0]   b_val;
    logic              b_wr;
    logic [AT_W-1:0]   src_at;

    always_comb begin
        accept    = arc_valid && arc_ready;
        clear_acc = accept && (arc_op == OP_CLEAR);
        b_sum     = {1'b0, a_src_at} + (AT_W+1)'(a_dly);
        b_ovf     = b_sum[AT_W];
        b_arc_at  = b_ovf ? '1 : b_sum[AT_W-1:0];
        b_dst_at  = at_mem[a_dst];
        b_wr      = a_vld && ((a_op == OP_ARC) || (a_op == OP_SEED));
        if (a_op == OP_SEED)
            b_val = AT_W'(a_dly);
        else
            b_val = (b_arc_at > b_dst_at) ? b_arc_at : b_dst_at;
        // Bypass the write landing this cycle so dependent back-to-back arcs see it.
        src_at = (b_wr && (a_dst == arc_src)) ? b_val : at_mem[arc_src];
    end

    always_ff @(posedge CK) begin
        if (!RST) begin
            if (state == S_CLR)
                at_mem[clr_cnt] <= '0;
            else if (b_wr)
                at_mem[a_dst] <= b_val;
        end
    end

    always_ff @(posedge CK) begin
        if (RST)
            qry_at <= '0;
        else
            qry_at <= at_mem[qry_node];
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state      <= S_CLR;
            clr_cnt    <= '0;
            arc_ready  <= 1'b0;
            a_vld      <= 1'b0;
            worst_at   <= '0;
            worst_node <= '0;
            sat        <= 1'b0;
        end else begin
            a_vld    <= accept && (arc_op != OP_CLEAR);
            a_op     <= arc_op;
            a_dst    <= arc_dst;
            a_dly    <= arc_delay;
            a_src_at <= src_at;

            case (state)
                S_CLR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == NODE_W'(NODES-1)) begin
                        state     <= S_RUN;
                        arc_ready <= 1'b1;
                    end
                end
                default: begin
                    if (clear_acc) begin
                        state     <= S_CLR;
                        clr_cnt   <= '0;
                        arc_ready <= 1'b0;
                    end
                end
            endcase

            if (clear_acc) begin
                worst_at   <= '0;
                worst_node <= '0;
                sat        <= 1'b0;
            end else begin
                // Strictly greater: ties keep the net that got there first.
                if (b_wr && (b_val > worst_at)) begin
                    worst_at   <= b_val;
                    worst_node <= a_dst;
                end
                if (b_wr && (a_op == OP_ARC) && b_ovf)
                    sat <= 1'b1;
            end
        end
    end

    assign busy = (state != S_RUN) || a_vld;

endmodule

// File: tb/tb_sta_arrival_engine.sv
// Scoreboard bench for sta_arrival_engine: directed arcs, serial reference model, decoupled monitor.
module tb_sta_arrival_engine;
    localparam int NODES  = 64;
    localparam int NODE_W = 6;
    localparam int DLY_W  = 16;
    localparam int AT_W   = 24;
    localparam longint unsigned MAXV = 64'd16777215;

    localparam int K_RDY = 0, K_BUSY = 1, K_WAT = 2, K_WNODE = 3, K_SAT = 4, K_QAT = 5;

    logic              CK = 1'b0;
    logic              RST = 1'b1;
    logic              arc_valid = 1'b0;
    logic              arc_ready;
    logic [1:0]        arc_op = '0;
    logic [NODE_W-1:0] arc_src = '0;
    logic [NODE_W-1:0] arc_dst = '0;
    logic [DLY_W-1:0]  arc_delay = '0;
    logic [NODE_W-1:0] qry_node = '0;
    logic [AT_W-1:0]   qry_at;
    logic [AT_W-1:0]   worst_at;
    logic [NODE_W-1:0] worst_node;
    logic              sat;
    logic              busy;

    sta_arrival_engine #(.NODES(NODES), .NODE_W(NODE_W), .DLY_W(DLY_W), .AT_W(AT_W)) dut (
        .CK(CK), .RST(RST),
        .arc_valid(arc_valid), .arc_ready(arc_ready), .arc_op(arc_op),
        .arc_src(arc_src), .arc_dst(arc_dst), .arc_delay(arc_delay),
        .qry_node(qry_node), .qry_at(qry_at),
        .worst_at(worst_at), .worst_node(worst_node), .sat(sat), .busy(busy)
    );

    always #5 CK = ~CK;

    typedef struct {
        int              kind;
        longint unsigned exp;
    } chk_t;

    chk_t            st_q[$];
    longint unsigned at_q[$];
    int              pass_cnt = 0;
    int              chk_cnt  = 0;
    logic            q_issue   = 1'b0;
    logic            q_issue_d = 1'b0;

    longint unsigned m_at[NODES];
    longint unsigned m_worst, m_wnode, m_sat;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge CK) q_issue_d <= q_issue;

    always @(negedge CK) begin
        chk_t            e;
        longint unsigned act;
        string           nm;
        if (q_issue_d) begin
            if (at_q.size() == 0) chk("qry_underflow", 0, 1);
            else chk("qry_at", qry_at, at_q.pop_front());
        end
        while (st_q.size() > 0) begin
            e = st_q.pop_front();
            case (e.kind)
                K_RDY:   begin act = arc_ready;  nm = "arc_ready";  end
                K_BUSY:  begin act = busy;       nm = "busy";       end
                K_WAT:   begin act = worst_at;   nm = "worst_at";   end
                K_WNODE: begin act = worst_node; nm = "worst_node"; end
                K_SAT:   begin act = sat;        nm = "sat";        end
                default: begin act = qry_at;     nm = "qry_at_rst"; end
            endcase
            chk(nm, act, e.exp);
        end
    end

    task automatic st_push(input int kind, input longint unsigned exp);
        chk_t e;
        e.kind = kind;
        e.exp  = exp;
        st_q.push_back(e);
    endtask

    task automatic status();
        st_push(K_WAT, m_worst);
        st_push(K_WNODE, m_wnode);
        st_push(K_SAT, m_sat);
    endtask

    function automatic void m_upd(input int dst, input longint unsigned nv);
        if (nv > m_worst) begin
            m_worst = nv;
            m_wnode = dst;
        end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NODES; i++) m_at[i] = 0;
        m_worst = 0;
        m_wnode = 0;
        m_sat   = 0;
    endfunction

    function automatic void m_apply(input logic [1:0] op, input int src, input int dst, input int dly);
        longint unsigned s, nv;
        case (op)
            2'd0: begin
                s = m_at[src] + longint'(dly);
                if (s > MAXV) begin
                    s = MAXV;
                    m_sat = 1;
                end
                nv = (s > m_at[dst]) ? s : m_at[dst];
                m_at[dst] = nv;
                m_upd(dst, nv);
            end
            2'd1: begin
                m_at[dst] = longint'(dly);
                m_upd(dst, longint'(dly));
            end
            2'd2: m_clear();
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input int src, input int dst, input int dly);
        int w = 0;
        while (!arc_ready && w < 200) begin
            tick();
            w++;
        end
        if (!arc_ready) chk("ready_timeout", 0, 1);
        arc_valid = 1'b1;
        arc_op    = op;
        arc_src   = NODE_W'(src);
        arc_dst   = NODE_W'(dst);
        arc_delay = DLY_W'(dly);
        tick();
        arc_valid = 1'b0;
        m_apply(op, src, dst, dly);
    endtask

    task automatic query_exp(input int node, input longint unsigned exp);
        qry_node = NODE_W'(node);
        q_issue  = 1'b1;
        at_q.push_back(exp);
        tick();
        q_issue = 1'b0;
    endtask

    task automatic query(input int node);
        query_exp(node, m_at[node]);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        m_clear();
        st_push(K_QAT, 0);
        status();
        for (int i = 0; i < NODES; i++) begin
            st_push(K_RDY, 0);
            st_push(K_BUSY, 1);
            tick();
        end
        st_push(K_RDY, 1);
        st_push(K_BUSY, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned v63;
        int cnt;

        // 1: reset sweep, then everything reads zero
        do_reset();
        for (int n = 0; n < NODES; n++) query(n);

        // 2: dependent chain back-to-back
        send(2'd1, 0, 1, 0);
        send(2'd0, 1, 2, 1157);
        send(2'd0, 2, 3, 6069);
        tick();
        st_push(K_BUSY, 0);
        status();
        query(2);
        query(3);
        chk("model_at3", m_at[3], 7226);

        // 3: reconvergence in both orders, tie and lowering SEED
        send(2'd1, 0, 4, 1000);
        send(2'd1, 0, 5, 3000);
        send(2'd0, 4, 6, 6255);
        send(2'd0, 5, 6, 4426);
        tick();
        query(6);
        send(2'd1, 0, 6, 0);
        send(2'd0, 5, 6, 4426);
        send(2'd0, 4, 6, 6255);
        tick();
        query(6);
        status();
        send(2'd1, 0, 10, 7426);
        tick();
        status();
        send(2'd1, 0, 6, 5);
        tick();
        status();
        query(6);

        // 4: saturation through a ping-pong chain
        send(2'd1, 0, 7, 65535);
        send(2'd0, 7, 8, 65535);
        tick();
        status();
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) send(2'd0, 8, 9, 65535);
            else            send(2'd0, 9, 8, 65535);
        end
        tick();
        query(8);
        query(9);
        status();
        send(2'd3, 1, 2, 9);
        send(2'd1, 0, 11, 5);
        tick();
        status();
        query(11);
        query(2);

        // 5: CLEAR right behind an ARC; the ARC's write must land first
        send(2'd0, 3, 63, 100);
        v63 = m_at[63];
        send(2'd2, 0, 0, 0);
        st_push(K_RDY, 0);
        st_push(K_BUSY, 1);
        query_exp(63, v63);
        status();
        cnt = 0;
        while (!arc_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("clear_sweep_len", cnt, 63);
        for (int n = 0; n < NODES; n++) query(n);
        status();

        // 6: reset one cycle after accepting an ARC
        send(2'd1, 0, 12, 500);
        tick();
        send(2'd0, 12, 13, 40);
        do_reset();
        query(13);
        query(12);
        status();

        tick();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
